fifo_n2w: RTL and testbench
===========================

Name: fifo_n2w

Overview:
- Narrow-to-wide FIFO: accepts one DATA_WIDTH word per write and delivers one 2*DATA_WIDTH word per read.
- It is the complement of the existing wide-write/narrow-read FIFO. It sits on the return path, packing byte streams into double-width words for the consumer.
- Storage, pointers and status logic are contained in this block.

Parameters:
- ADDR_WIDTH, 3, log2 of storage depth in narrow entries (DEPTH = 2**ADDR_WIDTH); legal range 1 or more.
- DATA_WIDTH, 8, width of one write word; read width is 2*DATA_WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr  input  1  write request; accepted only when full=0.
- rd  input  1  read request; accepted only when empty=0.
- w_data  input  DATA_WIDTH  narrow write data.
- r_data  output  2*DATA_WIDTH  oldest two entries, packed.
- full  output  1  high when count == DEPTH.
- empty  output  1  high when count < 2, i.e. no complete wide word is available.
- count  output  ADDR_WIDTH+1  number of narrow entries stored, 0..DEPTH.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset state:
  - w_ptr=0, r_ptr=0, count=0.
  - empty=1, full=0.
  - Storage array is not reset; r_data is don't-care while empty=1.
- Write acceptance:
  - Write is accepted when wr & ~full, evaluated on the pre-edge state.
  - On acceptance, mem[w_ptr] <= w_data and w_ptr <= w_ptr+1 (mod DEPTH).
- Read acceptance:
  - Read is accepted when rd & ~empty, evaluated on the pre-edge state.
  - On acceptance, r_ptr <= r_ptr+2 (mod DEPTH).
- r_data (first-word-fall-through, combinational from storage):
  - r_data = {mem[r_ptr+1], mem[r_ptr]}.
  - The earlier-written narrow word occupies r_data[DATA_WIDTH-1:0].
  - r_data is valid in the same cycle empty deasserts. Zero read latency.
- Pointer invariant: r_ptr is always even, so r_ptr+1 never wraps. DEPTH is even for ADDR_WIDTH of 1 or more.
- count update, per accepted operation:
  - write only: +1
  - read only: -2
  - both: -1
  - neither: hold
- Flags are registered or derived combinationally from count, and must reflect the post-edge count in the cycle after the edge:
  - full = (count == DEPTH)
  - empty = (count < 2)
- Odd residue: count==1 leaves empty=1. The lone narrow word stays stored until its partner arrives. There is no flush or partial read.
- Ignored requests:
  - wr while full: no state change, data is dropped.
  - rd while empty (count 0 or 1): no state change.
- Simultaneous wr & rd:
  - When full: read accepted, write rejected (full is sampled before the edge). count goes DEPTH to DEPTH-2.
  - When count==1: write accepted, read rejected. count becomes 2 and empty falls next cycle.
  - When 2 ≤ count < DEPTH: both accepted. New data written to mem[w_ptr] never aliases the two words being read.
- Wrap-around: both pointers wrap modulo DEPTH without gaps. Ordering is preserved across any number of wraps.
- Reset mid-operation: reset asserted at any time immediately returns to the reset state, independent of clk. All stored data is discarded.

Test Plan:
1. Reset, then write 0x11 and 0x22 with no reads. Required: empty=1 with count=1 after the first write; empty=0, count=2 and r_data=0x2211 after the second.
2. Write 0x01..0x08 (DEPTH=8). Required: full=1, count=8. A 9th write of 0xFF is ignored. Four reads return 0x0201, 0x0403, 0x0605, 0x0807, then empty=1 and count=0.
3. Fill to full, then assert wr=1 (0xAA) and rd=1 for one cycle. Required: read accepted, write dropped, count=6, full=0, next r_data=0x0403.
4. With count=3 (0x10, 0x20, 0x30), assert wr=1 (0x40) and rd=1 together. Required: count=2, r_data becomes 0x4030.
5. Stream 40 bytes with random wr/rd gaps, forcing repeated pointer wrap. Required: every read equals {byte[2k+1], byte[2k]} in order, with no loss or duplication.
6. Reset asynchronously mid-stream (count=5, between clock edges). Required: empty=1, full=0, count=0 immediately. The next two writes 0xC1 and 0xC2 produce r_data=0xC2C1.

Source files
------------

// File: rtl/fifo_n2w.sv
// Narrow-to-wide FIFO: one DATA_WIDTH word written per cycle, one 2*DATA_WIDTH word read per cycle.
// First-word-fall-through read port; the earlier narrow word lands in the low half of r_data.
module fifo_n2w #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr,
    input  logic                    rd,
    input  logic [DATA_WIDTH-1:0]   w_data,
    output logic [2*DATA_WIDTH-1:0] r_data,
    output logic                    full,
    output logic                    empty,
    output logic [ADDR_WIDTH:0]     count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_TWO   = (ADDR_WIDTH + 1)'(2);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_TWO   = ADDR_WIDTH'(2);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] w_ptr;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  wr_ok;
    logic                  rd_ok;

    // Flags follow the registered count, so they reflect the post-edge state.
    assign full  = (count == CNT_DEPTH);
    assign empty = (count < CNT_TWO);

    assign wr_ok = wr & ~full;
    assign rd_ok = rd & ~empty;

    // r_ptr only ever advances by two from zero, so OR-ing in bit 0 gives r_ptr+1 without a carry.
    assign r_data = {mem[r_ptr | PTR_ONE], mem[r_ptr]};

    // NOTE: storage has no reset; contents are don't-care until written, and a reset-free
    // array maps onto plain RAM instead of a bank of resettable flops.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[w_ptr] <= w_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
            count <= '0;
        end else begin
            if (wr_ok) begin
                w_ptr <= w_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                r_ptr <= r_ptr + PTR_TWO;
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_TWO;
                2'b11:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_n2w.sv
// Directed bench for fifo_n2w (ADDR_WIDTH=3, DATA_WIDTH=8): reset, packing order, full/empty
// boundaries, simultaneous requests, a wrapping stream against a queue model, and async reset.
module tb_fifo_n2w;

    localparam int ADDR_WIDTH = 3;
    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    wr;
    logic                    rd;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [2*DATA_WIDTH-1:0] r_data;
    logic                    full;
    logic                    empty;
    logic [ADDR_WIDTH:0]     count;

    int checks = 0;
    int errors = 0;

    fifo_n2w #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr),
        .rd     (rd),
        .w_data (w_data),
        .r_data (r_data),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    always #5 clk = ~clk;

    // Inputs are applied 1 time unit after a rising edge; outputs are sampled at that same point.
    task automatic cycle(input logic w, input logic r, input logic [DATA_WIDTH-1:0] d);
        wr     = w;
        rd     = r;
        w_data = d;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic do_reset();
        wr     = 1'b0;
        rd     = 1'b0;
        w_data = '0;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || count !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: empty=%b full=%b count=%0d, want empty=1 full=0 count=0",
                     empty, full, count);
        end
    endtask

    task automatic test_two_writes();
        do_reset();
        cycle(1'b1, 1'b0, 8'h11);
        checks++;
        if (empty !== 1'b1 || count !== 4'd1) begin
            errors++;
            $display("FAIL odd_residue: empty=%b count=%0d, want empty=1 count=1", empty, count);
        end
        cycle(1'b1, 1'b0, 8'h22);
        checks++;
        if (empty !== 1'b0 || count !== 4'd2) begin
            errors++;
            $display("FAIL pair_ready: empty=%b count=%0d, want empty=0 count=2", empty, count);
        end
        checks++;
        if (r_data !== 16'h2211) begin
            errors++;
            $display("FAIL pack_order: r_data=%h, want 2211", r_data);
        end
    endtask

    task automatic test_fill_drain();
        logic [15:0] exp_words [4] = '{16'h0201, 16'h0403, 16'h0605, 16'h0807};
        do_reset();
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b1, 1'b0, 8'(i));
        end
        checks++;
        if (full !== 1'b1 || count !== 4'd8) begin
            errors++;
            $display("FAIL fill_full: full=%b count=%0d, want full=1 count=8", full, count);
        end
        cycle(1'b1, 1'b0, 8'hFF);
        checks++;
        if (full !== 1'b1 || count !== 4'd8) begin
            errors++;
            $display("FAIL wr_when_full: full=%b count=%0d, want full=1 count=8", full, count);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (r_data !== exp_words[k]) begin
                errors++;
                $display("FAIL drain_word%0d: r_data=%h, want %h", k, r_data, exp_words[k]);
            end
            cycle(1'b0, 1'b1, 8'h00);
        end
        checks++;
        if (empty !== 1'b1 || count !== 4'd0 || full !== 1'b0) begin
            errors++;
            $display("FAIL drained: empty=%b full=%b count=%0d, want empty=1 full=0 count=0",
                     empty, full, count);
        end
        cycle(1'b0, 1'b1, 8'h00);
        checks++;
        if (empty !== 1'b1 || count !== 4'd0) begin
            errors++;
            $display("FAIL rd_when_empty: empty=%b count=%0d, want empty=1 count=0", empty, count);
        end
    endtask

    task automatic test_full_wr_rd();
        do_reset();
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b1, 1'b0, 8'(i));
        end
        cycle(1'b1, 1'b1, 8'hAA);
        checks++;
        if (count !== 4'd6 || full !== 1'b0) begin
            errors++;
            $display("FAIL full_wr_rd_count: count=%0d full=%b, want count=6 full=0", count, full);
        end
        checks++;
        if (r_data !== 16'h0403) begin
            errors++;
            $display("FAIL full_wr_rd_data: r_data=%h, want 0403", r_data);
        end
        // The dropped 0xAA must not appear: draining leaves 0605, 0807, then empty.
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 8'h00);
        checks++;
        if (r_data !== 16'h0807 || count !== 4'd2) begin
            errors++;
            $display("FAIL full_wr_dropped: r_data=%h count=%0d, want 0807 count=2", r_data, count);
        end
    endtask

    task automatic test_count1_wr_rd();
        do_reset();
        cycle(1'b1, 1'b0, 8'h5A);
        cycle(1'b1, 1'b1, 8'hA5);
        checks++;
        if (count !== 4'd2 || empty !== 1'b0 || r_data !== 16'hA55A) begin
            errors++;
            $display("FAIL count1_wr_rd: count=%0d empty=%b r_data=%h, want 2 0 a55a",
                     count, empty, r_data);
        end
    endtask

    task automatic test_count3_wr_rd();
        do_reset();
        cycle(1'b1, 1'b0, 8'h10);
        cycle(1'b1, 1'b0, 8'h20);
        cycle(1'b1, 1'b0, 8'h30);
        checks++;
        if (r_data !== 16'h2010 || count !== 4'd3) begin
            errors++;
            $display("FAIL count3_pre: r_data=%h count=%0d, want 2010 count=3", r_data, count);
        end
        cycle(1'b1, 1'b1, 8'h40);
        checks++;
        if (count !== 4'd2 || r_data !== 16'h4030) begin
            errors++;
            $display("FAIL count3_wr_rd: count=%0d r_data=%h, want count=2 4030", count, r_data);
        end
    endtask

    task automatic test_stream();
        logic [7:0] q [$];
        int         sent      = 0;
        int         words     = 0;
        int         cycles    = 0;
        int         bad_data  = 0;
        int         bad_count = 0;
        logic       w_req;
        logic       r_req;
        logic       w_acc;
        logic       r_acc;
        logic [7:0] b;
        do_reset();
        while (words < 20 && cycles < 2000) begin
            w_req = (sent < 40) && ($urandom_range(0, 2) != 0);
            r_req = ($urandom_range(0, 1) != 0);
            w_acc = w_req && (q.size() != DEPTH);
            r_acc = r_req && (q.size() >= 2);
            b     = 8'((sent * 37 + 5) & 8'hFF);
            wr     = w_req;
            rd     = r_req;
            w_data = b;
            #1;
            if (r_acc) begin
                checks++;
                if (r_data !== {q[1], q[0]}) begin
                    errors++;
                    bad_data++;
                    $display("FAIL stream_word%0d: r_data=%h, want %h", words, r_data, {q[1], q[0]});
                end
                void'(q.pop_front());
                void'(q.pop_front());
                words++;
            end
            if (w_acc) begin
                q.push_back(b);
                sent++;
            end
            @(posedge clk);
            #1;
            wr = 1'b0;
            rd = 1'b0;
            cycles++;
            if (count !== 4'(q.size())) begin
                bad_count++;
            end
        end
        checks++;
        if (words != 20 || sent != 40) begin
            errors++;
            $display("FAIL stream_timeout: words=%0d sent=%0d, want words=20 sent=40", words, sent);
        end
        checks++;
        if (bad_count != 0) begin
            errors++;
            $display("FAIL stream_count: %0d cycles with count off model, want 0", bad_count);
        end
        checks++;
        if (empty !== 1'b1 || count !== 4'd0) begin
            errors++;
            $display("FAIL stream_end: empty=%b count=%0d, want empty=1 count=0", empty, count);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 8'(8'h60 + i));
        end
        checks++;
        if (count !== 4'd5) begin
            errors++;
            $display("FAIL async_pre: count=%0d, want 5", count);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || count !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: empty=%b full=%b count=%0d, want empty=1 full=0 count=0",
                     empty, full, count);
        end
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 8'hC1);
        cycle(1'b1, 1'b0, 8'hC2);
        checks++;
        if (r_data !== 16'hC2C1 || count !== 4'd2) begin
            errors++;
            $display("FAIL async_after: r_data=%h count=%0d, want c2c1 count=2", r_data, count);
        end
    endtask

    initial begin
        reset  = 1'b1;
        wr     = 1'b0;
        rd     = 1'b0;
        w_data = '0;
        #1;
        checks++;
        if (count !== 4'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_async_entry: count=%0d empty=%b, want 0 1", count, empty);
        end
        @(posedge clk);
        #1;
        test_reset();
        test_two_writes();
        test_fill_drain();
        test_full_wr_rd();
        test_count1_wr_rd();
        test_count3_wr_rd();
        test_stream();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
